// File: rtl/insn_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes, the canonical NOP and the request bundle live here.
package insn_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Which register/function fields each format keeps
    localparam logic [31:0] MASK_R  = 32'hFFFF_FF80;
    localparam logic [31:0] MASK_I  = 32'h000F_FF80;
    localparam logic [31:0] MASK_SB = 32'h01FF_F000;
    localparam logic [31:0] MASK_UJ = 32'h0000_0F80;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= FMT_J;
    endfunction

endpackage

// File: rtl/insn_enc_imm_scatter.sv
// Per-format immediate scattering and error flag for the encoder.
// Range/alignment checking exists only with INSN_ENC_RANGE_CHECK_EN.
module insn_enc_imm_scatter
    import insn_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] bits,
    output logic        err
);

    always_comb begin
        bits = '0;
        unique case (1'b1)
            (fmt == FMT_I): bits = {imm[11:0], 20'b0};
            (fmt == FMT_S): bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            (fmt == FMT_B): bits = {imm[12], imm[10:5], 13'b0,
                                    imm[4:1], imm[11], 7'b0};
            (fmt == FMT_U): bits = {imm[31:12], 12'b0};
            (fmt == FMT_J): bits = {imm[20], imm[10:1], imm[11],
                                    imm[19:12], 12'b0};
            default:        bits = '0;
        endcase
    end

`ifdef INSN_ENC_RANGE_CHECK_EN
    // A value fits an n-bit signed field when bits [31:n-1] all match
    logic fit12;
    logic fit13;
    logic fit21;

    assign fit12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fit13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fit21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        err = 1'b0;
        unique case (1'b1)
            (fmt == FMT_R):                 err = 1'b0;
            (fmt == FMT_I), (fmt == FMT_S): err = !fit12;
            (fmt == FMT_B):                 err = !fit13 || imm[0];
            (fmt == FMT_U):                 err = |imm[11:0];
            (fmt == FMT_J):                 err = !fit21 || imm[0];
            default:                        err = 1'b1;
        endcase
    end
`else
    assign err = !fmt_legal(fmt);
`endif

endmodule

// File: rtl/insn_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready on both sides.
// Define INSN_ENC_RANGE_CHECK_EN to flag immediates that do not fit.
module insn_encoder
    import insn_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       fmt_i,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      insn_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cnt_o
);

    req_t             req;
    req_t             s1_req;
    logic             s1_valid;
    logic             s2_valid;
    logic [31:0]      s2_insn;
    logic             s2_err;
    logic [CNT_W-1:0] cnt;

    logic             s2_hold;
    logic             s1_adv;
    logic [31:0]      imm_bits;
    logic             imm_err;
    logic [31:0]      fields;
    logic [31:0]      mask;
    logic [31:0]      word;

    always_comb begin
        req.fmt    = fmt_i;
        req.opcode = opcode_i;
        req.rd     = rd_i;
        req.rs1    = rs1_i;
        req.rs2    = rs2_i;
        req.funct3 = funct3_i;
        req.funct7 = funct7_i;
        req.imm    = imm_i;
    end

    assign s2_hold    = s2_valid && !out_ready_i;
    assign s1_adv     = s1_valid && !s2_hold;
    assign in_ready_o = !s1_valid || s1_adv;

    insn_enc_imm_scatter u_scatter (
        .fmt  (s1_req.fmt),
        .imm  (s1_req.imm),
        .bits (imm_bits),
        .err  (imm_err)
    );

    assign fields = {s1_req.funct7, s1_req.rs2, s1_req.rs1,
                     s1_req.funct3, s1_req.rd, 7'b0};

    always_comb begin
        mask = '0;
        unique case (1'b1)
            (s1_req.fmt == FMT_R):                        mask = MASK_R;
            (s1_req.fmt == FMT_I):                        mask = MASK_I;
            (s1_req.fmt == FMT_S), (s1_req.fmt == FMT_B): mask = MASK_SB;
            (s1_req.fmt == FMT_U), (s1_req.fmt == FMT_J): mask = MASK_UJ;
            default:                                      mask = '0;
        endcase
    end

    always_comb begin
        word = {25'b0, s1_req.opcode} | imm_bits | (fields & mask);
        if (!fmt_legal(s1_req.fmt)) begin
            word = NOP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_req <= req;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s2_valid <= 1'b0;
            s2_insn  <= '0;
            s2_err   <= 1'b0;
        end else if (!s2_hold) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_insn <= word;
                s2_err  <= imm_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (s2_valid && out_ready_i) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out_valid_o = s2_valid;
    assign insn_o      = s2_insn;
    assign err_o       = s2_err;
    assign cnt_o       = cnt;

endmodule
